io_bus_ctrl: RTL and testbench

Parametrised memory-mapped I/O bus controller between the CPU memory port and `NUM_SLV` peripheral channels (RAM controller, UART, keyboard adapter, VGA buffer, flash bridge). It replaces fixed per-device routing with base/mask address decoding and a uniform en/ack handshake. It stalls the CPU through a pause request until the selected slave acknowledges. Unmapped accesses, and timed-out accesses when enabled, are reported as a bus error with the faulting address latched.

---
 rtl/io_bus_ctrl.sv | 162 ++++++++++++++++
 tb/tb_io_bus_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped I/O bus controller between the CPU memory port
// and NUM_SLV peripheral channels. It decodes each access by base/mask
// compare, where the lowest matching index wins, and drives a one-hot
// en/ack handshake.
//
// Optional feature: define IO_TIMEOUT_EN to abort an ACCESS that sees no ack
// within TIMEOUT cycles. The abort is reported as a bus error.

module io_bus_ctrl #(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned NUM_SLV = 4,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE = {16'hBF00, 16'hBF10, 16'h8000, 16'h0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {16'hFFF0, 16'hFFF0, 16'hC000, 16'h8000},
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_en_i,
    input  logic                      cpu_we_i,
    input  logic [ADDR_W-1:0]         cpu_addr_i,
    input  logic [DATA_W-1:0]         cpu_wdata_i,
    output logic [DATA_W-1:0]         cpu_rdata_o,
    output logic                      cpu_pause_o,
    output logic                      cpu_err_o,
    output logic [ADDR_W-1:0]         err_addr_o,
    output logic [NUM_SLV-1:0]        slv_en_o,
    output logic                      slv_we_o,
    output logic [ADDR_W-1:0]         slv_addr_o,
    output logic [DATA_W-1:0]         slv_wdata_o,
    input  logic [NUM_SLV*DATA_W-1:0] slv_rdata_i,
    input  logic [NUM_SLV-1:0]        slv_ack_i
);

    localparam int unsigned SEL_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StDone,
        StErr
    } state_e;

    state_e              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [NUM_SLV-1:0]  r_slv_en;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [ADDR_W-1:0]   r_err_addr;
`ifdef IO_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0]          r_cnt;
`endif

    logic                w_hit;
    logic [SEL_W-1:0]    w_sel;
    logic [NUM_SLV-1:0]  w_onehot;
    logic                w_ack;
    logic [DATA_W-1:0]   w_rdata;

    // Address decode: scan from the top down so the lowest matching index is kept last
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if ((cpu_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                w_hit = 1'b1;
                w_sel = SEL_W'(i);
            end
        end
        w_onehot = NUM_SLV'(1) << w_sel;
    end

    // Ack and read data of the selected channel only; other channels are ignored
    always_comb begin
        w_ack   = slv_ack_i[r_sel];
        w_rdata = slv_rdata_i[r_sel*DATA_W +: DATA_W];
    end

    // Main FSM with registered slave-side and CPU-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= StIdle;
            r_sel      <= '0;
            r_slv_en   <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
`ifdef IO_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (cpu_en_i) begin
                        r_we    <= cpu_we_i;
                        r_addr  <= cpu_addr_i;
                        r_wdata <= cpu_wdata_i;
                        if (w_hit) begin
                            r_sel    <= w_sel;
                            r_slv_en <= w_onehot;
`ifdef IO_TIMEOUT_EN
                            r_cnt    <= '0;
`endif
                            r_state  <= StAccess;
                        end else begin
                            r_err_addr <= cpu_addr_i;
                            r_err      <= 1'b1;
                            r_rdata    <= '0;
                            r_state    <= StErr;
                        end
                    end
                end
                StAccess: begin
                    if (w_ack) begin
                        if (!r_we) begin
                            r_rdata <= w_rdata;
                        end
                        r_slv_en <= '0;
                        r_state  <= StDone;
                    end
`ifdef IO_TIMEOUT_EN
                    // This cycle is the TIMEOUT-th without ack
                    else if (r_cnt == TO_LAST) begin
                        r_slv_en   <= '0;
                        r_err_addr <= r_addr;
                        r_err      <= 1'b1;
                        r_rdata    <= '0;
                        r_state    <= StErr;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
`endif
                end
                StDone:  r_state <= StIdle;
                StErr:   r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    // Pause is the only combinational output: request in IDLE, or waiting in ACCESS
    always_comb begin
        cpu_pause_o = ((r_state == StIdle) && cpu_en_i) || (r_state == StAccess);
    end

    assign cpu_rdata_o = r_rdata;
    assign cpu_err_o   = r_err;
    assign err_addr_o  = r_err_addr;
    assign slv_en_o    = r_slv_en;
    assign slv_we_o    = r_we;
    assign slv_addr_o  = r_addr;
    assign slv_wdata_o = r_wdata;

endmodule

// File: tb/tb_io_bus_ctrl.sv
// Directed bench for io_bus_ctrl using the default address map.
// The default map is as follows:
//   slave 0: base 0x0000, mask 0x8000. It covers every address with bit 15 = 0.
//   slave 1: base 0x8000, mask 0xC000. It covers 0x8000..0xBFFF.
//   slave 2: base 0xBF10, mask 0xFFF0. Slave 1 shadows it.
//   slave 3: base 0xBF00, mask 0xFFF0. Slave 1 shadows it.
//   0xC000..0xFFFF is unmapped.

module tb_io_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        cpu_en_i;
    logic        cpu_we_i;
    logic [15:0] cpu_addr_i;
    logic [15:0] cpu_wdata_i;
    logic [15:0] cpu_rdata_o;
    logic        cpu_pause_o;
    logic        cpu_err_o;
    logic [15:0] err_addr_o;
    logic [3:0]  slv_en_o;
    logic        slv_we_o;
    logic [15:0] slv_addr_o;
    logic [15:0] slv_wdata_o;
    logic [63:0] slv_rdata_i;
    logic [3:0]  slv_ack_i;

    int n_asserts = 0;
    int n_fail    = 0;

    io_bus_ctrl #(
        .TIMEOUT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_en_i    (cpu_en_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_wdata_i (cpu_wdata_i),
        .cpu_rdata_o (cpu_rdata_o),
        .cpu_pause_o (cpu_pause_o),
        .cpu_err_o   (cpu_err_o),
        .err_addr_o  (err_addr_o),
        .slv_en_o    (slv_en_o),
        .slv_we_o    (slv_we_o),
        .slv_addr_o  (slv_addr_o),
        .slv_wdata_o (slv_wdata_o),
        .slv_rdata_i (slv_rdata_i),
        .slv_ack_i   (slv_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [15:0] addr, input logic [15:0] wdata);
        cpu_en_i    = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wdata;
        #1;
    endtask

    initial begin
        rst         = 1'b0;
        cpu_en_i    = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = '0;
        cpu_wdata_i = '0;
        slv_ack_i   = '0;
        slv_rdata_i = {16'h3333, 16'h2222, 16'h1111, 16'hBEEF};

        // ---- reset state ----
        tick();
        tick();
        chk("rst_rdata", 32'(cpu_rdata_o), 32'h0);
        chk("rst_err_addr", 32'(err_addr_o), 32'h0);
        chk("rst_slv_en", 32'(slv_en_o), 32'h0);
        chk("rst_slv_we", 32'(slv_we_o), 32'h0);
        chk("rst_slv_addr", 32'(slv_addr_o), 32'h0);
        chk("rst_slv_wdata", 32'(slv_wdata_o), 32'h0);
        chk("rst_err", 32'(cpu_err_o), 32'h0);
        chk("rst_pause_lo", 32'(cpu_pause_o), 32'h0);
        cpu_en_i = 1'b1;
        #1;
        chk("rst_pause_follows_en", 32'(cpu_pause_o), 32'h1);
        cpu_en_i = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // ---- read 0x1234 -> slave 0, ack on the second ACCESS cycle ----
        req(1'b0, 16'h1234, 16'h0);
        chk("rd_pause_c0", 32'(cpu_pause_o), 32'h1);
        chk("rd_en_c0", 32'(slv_en_o), 32'h0);
        tick();
        chk("rd_en_c1", 32'(slv_en_o), 32'b0001);
        chk("rd_addr_c1", 32'(slv_addr_o), 32'h1234);
        chk("rd_we_c1", 32'(slv_we_o), 32'h0);
        chk("rd_pause_c1", 32'(cpu_pause_o), 32'h1);
        tick();
        slv_ack_i = 4'b0001;
        #1;
        chk("rd_pause_c2", 32'(cpu_pause_o), 32'h1);
        tick();
        chk("rd_rdata_done", 32'(cpu_rdata_o), 32'hBEEF);
        chk("rd_pause_done", 32'(cpu_pause_o), 32'h0);
        chk("rd_en_done", 32'(slv_en_o), 32'h0);
        cpu_en_i  = 1'b0;
        slv_ack_i = '0;
        tick();
        chk("rd_rdata_idle", 32'(cpu_rdata_o), 32'hBEEF);

        // ---- write 0xBF01 <- 0x0041 -> slave 1, immediate ack ----
        req(1'b1, 16'hBF01, 16'h0041);
        tick();
        slv_ack_i = 4'b0010;
        chk("wr_en", 32'(slv_en_o), 32'b0010);
        chk("wr_we", 32'(slv_we_o), 32'h1);
        chk("wr_addr", 32'(slv_addr_o), 32'hBF01);
        chk("wr_wdata", 32'(slv_wdata_o), 32'h0041);
        tick();
        chk("wr_rdata_kept", 32'(cpu_rdata_o), 32'hBEEF);
        chk("wr_en_done", 32'(slv_en_o), 32'h0);
        chk("wr_err", 32'(cpu_err_o), 32'h0);
        cpu_en_i  = 1'b0;
        slv_ack_i = '0;
        tick();

        // ---- unmapped read 0xC000 -> ERR ----
        req(1'b0, 16'hC000, 16'h0);
        chk("um_pause_c0", 32'(cpu_pause_o), 32'h1);
        tick();
        chk("um_err", 32'(cpu_err_o), 32'h1);
        chk("um_err_addr", 32'(err_addr_o), 32'hC000);
        chk("um_en", 32'(slv_en_o), 32'h0);
        chk("um_rdata", 32'(cpu_rdata_o), 32'h0);
        chk("um_pause_err", 32'(cpu_pause_o), 32'h0);
        cpu_en_i = 1'b0;
        tick();
        chk("um_err_pulse", 32'(cpu_err_o), 32'h0);
        chk("um_err_addr_hold", 32'(err_addr_o), 32'hC000);

        // ---- overlap 0xBF05: slaves 1 and 3 match, lowest wins; spurious acks ignored ----
        req(1'b0, 16'hBF05, 16'h0);
        tick();
        chk("ov_en", 32'(slv_en_o), 32'b0010);
        slv_ack_i = 4'b1101;
        tick();
        chk("ov_pause_spur", 32'(cpu_pause_o), 32'h1);
        chk("ov_en_spur", 32'(slv_en_o), 32'b0010);
        slv_ack_i = 4'b0010;
        tick();
        chk("ov_rdata", 32'(cpu_rdata_o), 32'h1111);
        chk("ov_pause_done", 32'(cpu_pause_o), 32'h0);
        cpu_en_i  = 1'b0;
        slv_ack_i = '0;
        tick();

`ifdef IO_TIMEOUT_EN
        // ---- timeout: TIMEOUT = 4, no ack -> ERR after 4 ACCESS cycles ----
        req(1'b0, 16'h0010, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("to_pause_access", 32'(cpu_pause_o), 32'h1);
        end
        tick();
        chk("to_err", 32'(cpu_err_o), 32'h1);
        chk("to_err_addr", 32'(err_addr_o), 32'h0010);
        chk("to_en", 32'(slv_en_o), 32'h0);
        chk("to_rdata", 32'(cpu_rdata_o), 32'h0);
        cpu_en_i = 1'b0;
        tick();

        // ---- ack on the 4th ACCESS cycle wins over timeout ----
        slv_rdata_i[15:0] = 16'h5A5A;
        req(1'b0, 16'h0020, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            tick();
        end
        slv_ack_i = 4'b0001;
        tick();
        chk("to_ack_rdata", 32'(cpu_rdata_o), 32'h5A5A);
        chk("to_ack_err", 32'(cpu_err_o), 32'h0);
        chk("to_ack_err_addr", 32'(err_addr_o), 32'h0010);
        cpu_en_i  = 1'b0;
        slv_ack_i = '0;
        tick();
`else
        // ---- no timeout: ACCESS waits indefinitely ----
        slv_rdata_i[15:0] = 16'h5A5A;
        req(1'b0, 16'h0010, 16'h0);
        for (int c = 1; c <= 10; c++) begin
            tick();
        end
        chk("nt_pause_wait", 32'(cpu_pause_o), 32'h1);
        chk("nt_err_wait", 32'(cpu_err_o), 32'h0);
        chk("nt_en_wait", 32'(slv_en_o), 32'b0001);
        slv_ack_i = 4'b0001;
        tick();
        chk("nt_rdata", 32'(cpu_rdata_o), 32'h5A5A);
        cpu_en_i  = 1'b0;
        slv_ack_i = '0;
        tick();
`endif

        // ---- reset in the middle of ACCESS, then a fresh read ----
        req(1'b1, 16'h0040, 16'h1357);
        tick();
        chk("mr_en_access", 32'(slv_en_o), 32'b0001);
        cpu_en_i = 1'b0;
        rst      = 1'b0;
        #1;
        chk("mr_en", 32'(slv_en_o), 32'h0);
        chk("mr_we", 32'(slv_we_o), 32'h0);
        chk("mr_addr", 32'(slv_addr_o), 32'h0);
        chk("mr_wdata", 32'(slv_wdata_o), 32'h0);
        chk("mr_rdata", 32'(cpu_rdata_o), 32'h0);
        chk("mr_err_addr", 32'(err_addr_o), 32'h0);
        chk("mr_pause", 32'(cpu_pause_o), 32'h0);
        tick();
        rst = 1'b1;
        tick();
        chk("mr_idle_pause", 32'(cpu_pause_o), 32'h0);
        slv_rdata_i[15:0] = 16'h7777;
        req(1'b0, 16'h0030, 16'h0);
        tick();
        slv_ack_i = 4'b0001;
        tick();
        chk("mr_new_rdata", 32'(cpu_rdata_o), 32'h7777);
        chk("mr_new_pause", 32'(cpu_pause_o), 32'h0);
        cpu_en_i  = 1'b0;
        slv_ack_i = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
